// File: rtl/cache_line_ctrl_pkg.sv
// -----------------------------------------------------------------------------
// cache_line_ctrl_pkg
// Shared definitions for the direct-mapped cache miss controller:
//   - controller state encoding
//   - line geometry (words per line, word-counter width)
//   - address field positions, with helpers that derive the index width and
//     tag position from a given tag width.
// Address layout: {tag[TAG_W], index[INDEX_W], word offset[2], byte[2]}.
// -----------------------------------------------------------------------------
package cache_line_ctrl_pkg;

   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_WB   = 2'd1,
      ST_FILL = 2'd2
   } state_e;

   localparam int WORDS_PER_LINE = 4;
   localparam int CNT_W          = $clog2(WORDS_PER_LINE);

   localparam int ADDR_W         = 32;
   localparam int BYTE_BITS      = 2;
   localparam int WORD_LSB       = BYTE_BITS;            // word offset starts here
   localparam int INDEX_LSB      = WORD_LSB + CNT_W;     // set index starts here

   // Index takes whatever the tag leaves above the word offset.
   function automatic int index_w(input int tag_w);
      return ADDR_W - INDEX_LSB - tag_w;
   endfunction

   // Lowest address bit belonging to the tag.
   function automatic int tag_lsb(input int tag_w);
      return ADDR_W - tag_w;
   endfunction

endpackage

// File: rtl/cache_line_ctrl.sv
// -----------------------------------------------------------------------------
// cache_line_ctrl
// Miss-handling controller for a direct-mapped data cache built from 4-word
// line blocks. Hits (read and write) are served in the same cycle; a miss
// stalls the pipeline, writes back a dirty victim word by word, then refills
// the line from memory and lets the held request re-evaluate as a hit.
//
// Ports
//   CLK, Reset            clock (rising edge), synchronous active-high reset
//   Req, ReqWE, Addr,     CPU access from the MEM stage (held while Stall=1)
//   WData
//   Stall, RData          pipeline freeze and load data
//   Index                 set select to the line blocks
//   Valid, Dirty, Tag, RD state and data of the selected line
//   Offset, WE, SetValid, line block write port
//   SetDirty, SetTag, WD
//   MemReq, MemWE,        word-at-a-time memory bus; a transfer completes on
//   MemAddr, MemWData,    the edge where MemReq and MemReady are both high
//   MemRData, MemReady
//
// Only the state and the word counter are registered; every output is
// combinational from them and the inputs.
// -----------------------------------------------------------------------------
module cache_line_ctrl
   import cache_line_ctrl_pkg::*;
#(
   parameter  int TAG_W   = 26,
   localparam int INDEX_W = index_w(TAG_W)
) (
   input  logic               CLK,
   input  logic               Reset,
   // CPU side
   input  logic               Req,
   input  logic               ReqWE,
   input  logic [31:0]        Addr,
   input  logic [31:0]        WData,
   output logic               Stall,
   output logic [31:0]        RData,
   // line block side
   output logic [INDEX_W-1:0] Index,
   input  logic               Valid,
   input  logic               Dirty,
   input  logic [TAG_W-1:0]   Tag,
   input  logic [31:0]        RD,
   output logic [1:0]         Offset,
   output logic               WE,
   output logic               SetValid,
   output logic               SetDirty,
   output logic [TAG_W-1:0]   SetTag,
   output logic [31:0]        WD,
   // memory side
   output logic               MemReq,
   output logic               MemWE,
   output logic [31:0]        MemAddr,
   output logic [31:0]        MemWData,
   input  logic [31:0]        MemRData,
   input  logic               MemReady
);

   localparam logic [CNT_W-1:0] LAST_WORD = CNT_W'(WORDS_PER_LINE - 1);

   state_e             state_q, state_d;
   logic [CNT_W-1:0]   cnt_q, cnt_d;

   logic [TAG_W-1:0]   req_tag;
   logic [CNT_W-1:0]   req_word;
   logic               hit;
   logic               last_xfer;
   logic               unused_byte_bits;

   assign req_tag   = Addr[ADDR_W-1 -: TAG_W];
   assign req_word  = Addr[INDEX_LSB-1:WORD_LSB];
   assign Index     = Addr[INDEX_LSB +: INDEX_W];
   assign hit       = Req & Valid & (Tag == req_tag);
   assign last_xfer = MemReady & (cnt_q == LAST_WORD);

   // Byte-within-word bits play no part in a word cache.
   assign unused_byte_bits = ^Addr[BYTE_BITS-1:0];

   always_comb begin
      state_d  = state_q;
      cnt_d    = cnt_q;
      Stall    = 1'b0;
      RData    = RD;
      Offset   = req_word;
      WE       = 1'b0;
      SetValid = 1'b0;
      SetDirty = 1'b0;
      SetTag   = req_tag;
      WD       = WData;
      MemReq   = 1'b0;
      MemWE    = 1'b0;
      MemAddr  = {req_tag, Index, cnt_q, 2'b00};
      MemWData = RD;

      case (state_q)
         ST_IDLE: begin
            if (hit) begin
               // Stores merge into the line immediately and mark it dirty.
               if (ReqWE) begin
                  WE       = 1'b1;
                  SetValid = 1'b1;
                  SetDirty = 1'b1;
               end
            end else if (Req) begin
               Stall   = 1'b1;
               cnt_d   = '0;
               state_d = Dirty ? ST_WB : ST_FILL;
            end
         end

         ST_WB: begin
            // Victim address is rebuilt from the stored tag, not the request.
            Stall    = 1'b1;
            Offset   = cnt_q;
            MemReq   = 1'b1;
            MemWE    = 1'b1;
            MemAddr  = {Tag, Index, cnt_q, 2'b00};
            MemWData = RD;
            if (MemReady) begin
               cnt_d = cnt_q + 1'b1;
               if (last_xfer) state_d = ST_FILL;
            end
         end

         ST_FILL: begin
            Stall  = 1'b1;
            MemReq = 1'b1;
            Offset = cnt_q;
            if (MemReady) begin
               // The line only turns valid with its last word, so a fill cut
               // short never produces a hit. WData is never used here; a
               // store merges on the hit cycle that follows.
               WE       = 1'b1;
               WD       = MemRData;
               SetDirty = 1'b0;
               SetValid = (cnt_q == LAST_WORD);
               cnt_d    = cnt_q + 1'b1;
               if (last_xfer) state_d = ST_IDLE;
            end
         end

         default: begin
            state_d = ST_IDLE;
            cnt_d   = '0;
         end
      endcase

      // Reset freezes the pipeline and silences both write ports.
      if (Reset) begin
         Stall    = 1'b1;
         WE       = 1'b0;
         SetValid = 1'b0;
         SetDirty = 1'b0;
         MemReq   = 1'b0;
         MemWE    = 1'b0;
         state_d  = ST_IDLE;
         cnt_d    = '0;
      end
   end

   always_ff @(posedge CLK) begin
      if (Reset) begin
         state_q <= ST_IDLE;
         cnt_q   <= '0;
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
      end
   end

endmodule

// File: doc/cache_line_ctrl.md
# cache_line_ctrl

Miss-handling controller for one direct-mapped data cache built from 4-word line blocks. It compares the CPU address against the selected line, serves read and write hits in the same cycle, and otherwise stalls the pipeline. On a miss it writes back a dirty victim word by word and then refills the line from memory. It drives the line block's write port (`Offset`, `WE`, `SetValid`, `SetDirty`, `SetTag`, `WD`) and consumes its `Valid`, `Dirty`, `Tag` and `RD` outputs; it sits between the MEM stage and the memory bus.

## Interface
- `TAG_W`, default 26: tag width. Address split is {tag[TAG_W], index[INDEX_W], offset[2], byte[2]}.
- `INDEX_W`, derived as 28-TAG_W (2 at the default): set-index width.
- `CLK` input 1: clock, rising edge.
- `Reset` input 1: synchronous, active-high.
- `Req` input 1: CPU access valid. `Req`, `ReqWE`, `Addr` and `WData` are held stable while `Stall`=1.
- `ReqWE` input 1: 1 = store, 0 = load.
- `Addr` input 32: byte address; bits [1:0] are ignored.
- `WData` input 32: store data.
- `Stall` output 1: freeze pipeline.
- `RData` output 32: load data; valid when `Req`=1, `ReqWE`=0 and `Stall`=0.
- `Index` output INDEX_W: `Addr[INDEX_W+3:4]`; selects the line block.
- `Valid`, `Dirty` input 1 each: from the selected line.
- `Tag` input TAG_W: from the selected line.
- `RD` input 32: from the selected line, at the word given by `Offset`.
- `Offset` output 2: word select to the line.
- `WE`, `SetValid`, `SetDirty` output 1 each: line write controls.
- `SetTag` output TAG_W: line tag to write.
- `WD` output 32: line write data.
- `MemReq` output 1: memory word request.
- `MemWE` output 1: 1 = write word, 0 = read word.
- `MemAddr` output 32: word-aligned address.
- `MemWData` output 32: write data to memory.
- `MemRData` input 32: read data; valid when `MemReady`=1.
- `MemReady` input 1: completes the current word transfer in this cycle.

## Operation
- States: IDLE, WB, FILL. Registered state plus a 2-bit word counter `cnt`. All other outputs are combinational from state, `cnt` and inputs.
- Hit = `Req` & `Valid` & (`Tag` == `Addr[31:32-TAG_W]`).
- IDLE, read hit:
  - `Offset`=`Addr[3:2]`, `RData`=`RD`, `Stall`=0, `WE`=0.
- IDLE, write hit:
  - `WE`=1, `Offset`=`Addr[3:2]`, `WD`=`WData`, `SetValid`=1, `SetDirty`=1, `SetTag`=`Addr` tag, `Stall`=0.
- IDLE, miss (`Req` & !hit):
  - `Stall`=1, `WE`=0, `cnt`<=0.
  - Next state is WB if `Dirty`=1, otherwise FILL.
- IDLE, `Req`=0: `Stall`=0, no line write, no memory request.
- WB:
  - `Offset`=`cnt`, `MemReq`=1, `MemWE`=1, `MemAddr`={`Tag`, `Index`, `cnt`, 2'b00}, `MemWData`=`RD`, `Stall`=1.
  - On `MemReady`: `cnt`<=`cnt`+1.
  - At `cnt`==3 & `MemReady`: go to FILL with `cnt`<=0 (natural wrap).
- FILL:
  - `MemReq`=1, `MemWE`=0, `MemAddr`={`Addr` tag, `Index`, `cnt`, 2'b00}, `Stall`=1.
  - On `MemReady`: `WE`=1, `Offset`=`cnt`, `WD`=`MemRData`, `SetTag`=`Addr` tag, `SetDirty`=0, `SetValid`=(`cnt`==3), `cnt`<=`cnt`+1.
  - At `cnt`==3 & `MemReady`: go to IDLE. The request then re-evaluates as a hit, and a store merges in that cycle.
- Boundaries:
  - `MemReady` while `MemReq`=0 is ignored.
  - `MemReady` low holds state, `cnt`, `MemAddr` and `MemWData` stable.
  - A write miss never writes `WData` during FILL.
  - A fill leaves the line invalid until its last word, so a partial line never hits.
- Reset mid-operation: on the reset edge, state<=IDLE and `cnt`<=0. The memory transfer is abandoned and the line is left invalid or partially filled. Any partial fill has `SetValid`=0, so no false hit results.

## Timing
- While `Reset`=1: `Stall`=1, `MemReq`=0, `WE`=0, `MemWE`=0.
- Once `Reset`=0, from the first edge onward: state IDLE and `cnt`=0.
- Hit: 0 added cycles.
- Clean miss: 1 (IDLE) + 4 FILL transfers + 1 (IDLE hit).
- Dirty miss: 1 (IDLE) + 4 WB transfers + 4 FILL transfers + 1 (IDLE hit).
- Each transfer takes at least 1 cycle; a transfer completes on the edge where `MemReq` & `MemReady` are both high.
- `Stall` falls combinationally in the hit cycle after the fill.

## Structure
- Shared package holds:
  - state encoding (IDLE=2'd0, WB=2'd1, FILL=2'd2);
  - `WORDS_PER_LINE`=4;
  - address field slice constants derived from `TAG_W`.
- No sub-module: FSM, counter and muxing live in one module. The line storage stays in the existing line block, instantiated per set by the cache top.

## Test plan
- Reset, then load with `Addr`=0x40 and an invalid line: `Stall`=1; one IDLE cycle; FILL reads 0x40, 0x44, 0x48, 0x4C; then `Stall`=0 with `RData` equal to the memory word at 0x40.
- Store 0xDEADBEEF to 0x44 after that fill: hit, `Stall`=0, and that cycle shows `WE`=1, `SetDirty`=1, `Offset`=1. A following load of 0x44 returns 0xDEADBEEF.
- Load 0x440, which has the same index and a different tag, while the 0x40 line is dirty: WB writes 0x40–0x4C including 0xDEADBEEF at 0x44, then FILL reads 0x440–0x44C.
- Memory with 3 wait cycles per word: `MemAddr` and `MemWData` stay stable across the waits. Total clean-miss stall = 1 + 16 + 0 cycles before the hit cycle.
- Assert `Reset` during FILL at `cnt`=2: on the next edge, `MemReq`=0 and state is IDLE. A repeat load misses and refills fully; a false hit is a failure.
- Store miss to 0x80 with a clean invalid line: no `WData` is written during FILL; after the fill, the store hits and sets `Dirty`.
